dmem_arbiter: RTL and testbench

//  Shares the single-port, byte-addressed, big-endian data memory between two requesters
//  (req0 = core load/store unit, req1 = debug/DMA port) with round-robin arbitration.

---
 rtl/dmem_arbiter.sv | 128 ++++++++++++
 tb/tb_dmem_arbiter.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin sharing of one registered-read data memory between two requesters.
// Handshake->rsp latency is 2 cycles for an access and 1 for a rejected request; ready only in IDLE, rsp has no backpressure.
module dmem_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MEM_BYTES = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              rsp0_valid,
  output logic              rsp0_err,
  output logic [DATA_W-1:0] rsp0_rdata,
  output logic              rsp1_valid,
  output logic              rsp1_err,
  output logic [DATA_W-1:0] rsp1_rdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_wd,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_read_data
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  // Comparing against the last legal word address avoids computing addr+4, which could wrap.
  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(MEM_BYTES - 4);

  state_t              state_q, state_d;
  logic                rr_last_q, rr_last_d;
  logic                id_q, id_d;
  logic                we_q, we_d;
  logic                err_q, err_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;

  logic                gnt_id;
  logic                sel_we;
  logic                sel_err;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;
  logic                in_access;
  logic                in_resp;
  logic [DATA_W-1:0]   rsp_rdata;

  always_comb begin
    gnt_id    = (req0_valid && req1_valid) ? ~rr_last_q : ~req0_valid;
    sel_we    = gnt_id ? req1_we    : req0_we;
    sel_addr  = gnt_id ? req1_addr  : req0_addr;
    sel_wdata = gnt_id ? req1_wdata : req0_wdata;
    sel_err   = (sel_addr[1:0] != 2'b00) || (sel_addr > LAST_WORD);
  end

  always_comb begin
    state_d    = state_q;
    rr_last_d  = rr_last_q;
    id_d       = id_q;
    we_d       = we_q;
    err_d      = err_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    case (state_q)
      IDLE: begin
        if (rst && (req0_valid || req1_valid)) begin
          req0_ready = ~gnt_id;
          req1_ready = gnt_id;
          rr_last_d  = gnt_id;
          id_d       = gnt_id;
          we_d       = sel_we;
          err_d      = sel_err;
          addr_d     = sel_addr;
          wdata_d    = sel_wdata;
          state_d    = sel_err ? RESP : ACCESS;
        end
      end
      ACCESS:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      rr_last_q <= 1'b1;
      id_q      <= 1'b0;
      we_q      <= 1'b0;
      err_q     <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      rr_last_q <= rr_last_d;
      id_q      <= id_d;
      we_q      <= we_d;
      err_q     <= err_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
    end
  end

  // Outputs decode straight from state so reset clears them without waiting for an edge.
  always_comb begin
    in_access   = (state_q == ACCESS);
    in_resp     = (state_q == RESP);
    mem_we      = in_access && we_q;
    mem_address = in_access ? addr_q  : '0;
    mem_wd      = in_access ? wdata_q : '0;
    rsp_rdata   = (in_resp && !we_q && !err_q) ? mem_read_data : '0;
    rsp0_valid  = in_resp && !id_q;
    rsp1_valid  = in_resp && id_q;
    rsp0_err    = rsp0_valid && err_q;
    rsp1_err    = rsp1_valid && err_q;
    rsp0_rdata  = id_q ? '0 : rsp_rdata;
    rsp1_rdata  = id_q ? rsp_rdata : '0;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed and random transactions against a transaction-level model
// with a byte-wide big-endian memory behind the DUT.
module tb_dmem_arbiter;
  localparam int MEM_BYTES = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, req0_we;
  logic [31:0] req0_addr, req0_wdata;
  logic        req1_valid, req1_ready, req1_we;
  logic [31:0] req1_addr, req1_wdata;
  logic        rsp0_valid, rsp0_err, rsp1_valid, rsp1_err;
  logic [31:0] rsp0_rdata, rsp1_rdata;
  logic [31:0] mem_address, mem_wd, mem_read_data;
  logic        mem_we;
  logic        mem_clr;

  int          checks = 0;
  int          errors = 0;
  bit          rr_last;
  logic [31:0] exp_mem [0:MEM_BYTES/4-1];

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_BYTES(MEM_BYTES)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .rsp0_valid(rsp0_valid), .rsp0_err(rsp0_err), .rsp0_rdata(rsp0_rdata),
    .rsp1_valid(rsp1_valid), .rsp1_err(rsp1_err), .rsp1_rdata(rsp1_rdata),
    .mem_address(mem_address), .mem_wd(mem_wd), .mem_we(mem_we),
    .mem_read_data(mem_read_data)
  );

  // Byte-addressed, big-endian memory with a registered read port.
  logic [7:0] mem_b [0:MEM_BYTES-1];
  wire  [9:0] ma = {mem_address[9:2], 2'b00};
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < MEM_BYTES; i++) mem_b[i] <= 8'h00;
    end else if (mem_we) begin
      mem_b[ma]         <= mem_wd[31:24];
      mem_b[ma + 10'd1] <= mem_wd[23:16];
      mem_b[ma + 10'd2] <= mem_wd[15:8];
      mem_b[ma + 10'd3] <= mem_wd[7:0];
    end
    mem_read_data <= {mem_b[ma], mem_b[ma + 10'd1], mem_b[ma + 10'd2], mem_b[ma + 10'd3]};
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit spec_err(input logic [31:0] a);
    return (a % 4 != 0) || (longint'(a) > longint'(MEM_BYTES - 4));
  endfunction

  // Offer up to two requests at once and follow them cycle by cycle until both are answered.
  task automatic run_pair(input bit v0, input bit we0, input logic [31:0] a0, input logic [31:0] d0,
                          input bit v1, input bit we1, input logic [31:0] a1, input logic [31:0] d1);
    bit          pend [2];
    bit          wer  [2];
    logic [31:0] ar   [2];
    logic [31:0] dr   [2];
    bit          e_rdy [2];
    int          busy = 0, rsp_in = -1, acc_in = -1, cyc = 0;
    bit          r_id = 0, r_err = 0, a_we = 0, w, e, granted;
    logic [31:0] r_dat = 0, a_addr = 0, a_wd = 0;
    pend[0] = v0; pend[1] = v1;
    wer[0] = we0; wer[1] = we1; ar[0] = a0; ar[1] = a1; dr[0] = d0; dr[1] = d1;
    @(posedge clk); #1;
    req0_valid = v0; req0_we = we0; req0_addr = a0; req0_wdata = d0;
    req1_valid = v1; req1_we = we1; req1_addr = a1; req1_wdata = d1;
    while ((pend[0] || pend[1] || busy > 0) && cyc < 30) begin
      @(negedge clk);
      cyc++;
      if (busy > 0) busy--;
      rsp_in--;
      acc_in--;
      for (int n = 0; n < 2; n++)
        e_rdy[n] = (busy == 0) && pend[n] && (!pend[1-n] || rr_last != n[0]);
      chk("req0_ready", {31'b0, req0_ready}, {31'b0, e_rdy[0]});
      chk("req1_ready", {31'b0, req1_ready}, {31'b0, e_rdy[1]});
      chk("rsp0_valid", {31'b0, rsp0_valid}, {31'b0, rsp_in == 0 && !r_id});
      chk("rsp1_valid", {31'b0, rsp1_valid}, {31'b0, rsp_in == 0 && r_id});
      chk("rsp0_err", {31'b0, rsp0_err}, {31'b0, rsp_in == 0 && !r_id && r_err});
      chk("rsp1_err", {31'b0, rsp1_err}, {31'b0, rsp_in == 0 && r_id && r_err});
      chk("rsp0_rdata", rsp0_rdata, (rsp_in == 0 && !r_id) ? r_dat : 32'h0);
      chk("rsp1_rdata", rsp1_rdata, (rsp_in == 0 && r_id) ? r_dat : 32'h0);
      chk("mem_we", {31'b0, mem_we}, {31'b0, acc_in == 0 && a_we});
      chk("mem_address", mem_address, (acc_in == 0) ? a_addr : 32'h0);
      chk("mem_wd", mem_wd, (acc_in == 0) ? a_wd : 32'h0);
      granted = e_rdy[0] || e_rdy[1];
      w = e_rdy[1];
      if (granted) begin
        rr_last = w;
        pend[w] = 1'b0;
        e       = spec_err(ar[w]);
        r_id    = w;
        r_err   = e;
        a_we    = wer[w];
        a_addr  = ar[w];
        a_wd    = dr[w];
        r_dat   = (e || wer[w]) ? 32'h0 : exp_mem[ar[w] / 4];
        if (!e && wer[w]) exp_mem[ar[w] / 4] = dr[w];
        rsp_in  = e ? 1 : 2;
        acc_in  = e ? -5 : 1;
        busy    = e ? 2 : 3;
      end
      @(posedge clk); #1;
      if (granted && !w) req0_valid = 1'b0;
      if (granted && w)  req1_valid = 1'b0;
    end
    chk("grant_timeout", {31'b0, pend[0] | pend[1]}, 32'h0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  initial begin
    bit          v0, v1, we0, we1;
    logic [31:0] a0, a1;
    for (int i = 0; i < MEM_BYTES / 4; i++) exp_mem[i] = 32'h0;
    rst = 1'b0; mem_clr = 1'b1;
    req0_valid = 1'b1; req0_we = 1'b1; req0_addr = 32'h0; req0_wdata = 32'h0;
    req1_valid = 1'b1; req1_we = 1'b1; req1_addr = 32'h4; req1_wdata = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req0_ready", {31'b0, req0_ready}, 32'h0);
    chk("rst_req1_ready", {31'b0, req1_ready}, 32'h0);
    chk("rst_rsp0_valid", {31'b0, rsp0_valid}, 32'h0);
    chk("rst_rsp1_valid", {31'b0, rsp1_valid}, 32'h0);
    chk("rst_mem_we", {31'b0, mem_we}, 32'h0);
    chk("rst_mem_address", mem_address, 32'h0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(posedge clk); #1; mem_clr = 1'b0;
    @(negedge clk); rst = 1'b1; rr_last = 1'b1;

    // store then load the same word
    run_pair(1, 1, 32'd8, 32'hA1B2C3D4, 0, 0, 32'h0, 32'h0);
    run_pair(1, 0, 32'd8, 32'h0, 0, 0, 32'h0, 32'h0);
    // both requesters loading: grants alternate, rsp only on the winner's channel
    for (int k = 0; k < 2; k++)
      run_pair(1, 0, 32'd8, 32'h0, 1, 0, $urandom_range(0, 15) * 4, 32'h0);
    // rejected requests, including the boundary just past the last word and address wrap
    run_pair(0, 0, 32'h0, 32'h0, 1, 0, 32'h2, 32'h0);
    run_pair(0, 0, 32'h0, 32'h0, 1, 0, MEM_BYTES, 32'h0);
    run_pair(0, 0, 32'h0, 32'h0, 1, 1, MEM_BYTES - 3, 32'h55AA55AA);
    run_pair(0, 0, 32'h0, 32'h0, 1, 1, 32'hFFFF_FFFC, 32'h55AA55AA);
    // last legal word
    run_pair(1, 1, MEM_BYTES - 4, 32'h11223344, 0, 0, 32'h0, 32'h0);
    run_pair(0, 0, 32'h0, 32'h0, 1, 0, MEM_BYTES - 4, 32'h0);

    for (int k = 0; k < 40; k++) begin
      v0  = 1'($urandom_range(0, 1));
      v1  = v0 ? 1'($urandom_range(0, 1)) : 1'b1;
      we0 = 1'($urandom_range(0, 1));
      we1 = 1'($urandom_range(0, 1));
      a0  = ($urandom_range(0, 7) == 0) ? $urandom : $urandom_range(0, 15) * 4;
      a1  = ($urandom_range(0, 7) == 0) ? $urandom : $urandom_range(0, 15) * 4;
      run_pair(v0, we0, a0, $urandom, v1, we1, a1, $urandom);
    end

    // reset during the ACCESS cycle of a store: the write is lost and no response appears
    run_pair(1, 1, 32'h40, 32'h0BAD_F00D, 0, 0, 32'h0, 32'h0);
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_we = 1'b1; req0_addr = 32'h40; req0_wdata = 32'hDEADBEEF;
    @(negedge clk);
    chk("mid_rst_ready", {31'b0, req0_ready}, 32'h1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    @(negedge clk);
    chk("mid_rst_access_we", {31'b0, mem_we}, 32'h1);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_we_drop", {31'b0, mem_we}, 32'h0);
    chk("mid_rst_addr_drop", mem_address, 32'h0);
    @(posedge clk); #1;
    chk("mid_rst_no_rsp", {31'b0, rsp0_valid | rsp1_valid}, 32'h0);
    @(negedge clk);
    rst = 1'b1; rr_last = 1'b1;
    run_pair(1, 0, 32'h40, 32'h0, 1, 0, 32'd8, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
